// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then accesses a word array with byte strobes and returns a one-cycle response.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [CW-1:0]  counter;
    logic           holdWe;
    logic [31:0]    holdAddr;
    logic [31:0]    holdWdata;
    logic [3:0]     holdWstrb;
    logic [31:0]    mem [DEPTH];

    logic           handshake;
    logic           enterResp;
    logic           accWe;
    logic [31:0]    accAddr;
    logic [31:0]    accWdata;
    logic [3:0]     accWstrb;
    logic           accFault;
    logic [AW-1:0]  wordIdx;

    assign req_ready = (state == IDLE) && rst;
    assign busy      = (state != IDLE);
    assign handshake = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (WAIT_CYCLES == 0) begin
                        nextState = RESP;
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (counter == CW'(1)) begin
                    nextState = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request capture and wait-state countdown
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter   <= '0;
            holdWe    <= 1'b0;
            holdAddr  <= '0;
            holdWdata <= '0;
            holdWstrb <= '0;
        end else if (handshake) begin
            counter   <= CW'(WAIT_CYCLES);
            holdWe    <= req_we;
            holdAddr  <= req_addr;
            holdWdata <= req_wdata;
            holdWstrb <= req_wstrb;
        end else if ((state == WAIT) && (counter != CW'(1))) begin
            counter <= counter - CW'(1);
        end
    end

    // With zero wait states the access happens on the handshake edge itself,
    // so the live request is used instead of the holding registers.
    always_comb begin
        accWe     = holdWe;
        accAddr   = holdAddr;
        accWdata  = holdWdata;
        accWstrb  = holdWstrb;
        if (state == IDLE) begin
            accWe    = req_we;
            accAddr  = req_addr;
            accWdata = req_wdata;
            accWstrb = req_wstrb;
        end
        enterResp = rst && (state != RESP) && (nextState == RESP);
        accFault  = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH));
        wordIdx   = accAddr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enterResp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= accFault;
            rsp_rdata <= (!accFault && !accWe) ? mem[wordIdx] : 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Array is not reset; only faultless stores entering RESP write it
    always_ff @(posedge clk) begin
        if (enterResp && !accFault && accWe) begin
            for (int i = 0; i < 4; i++) begin
                if (accWstrb[i]) begin
                    mem[wordIdx][8*i +: 8] <= accWdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked against
// directed vectors and a word-array reference model driven with random traffic.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        aReqValid = 1'b0, aReqWe = 1'b0;
    logic [31:0] aReqAddr = '0, aReqWdata = '0;
    logic [3:0]  aReqWstrb = '0;
    logic        aReqReady, aRspValid, aRspErr, aBusy;
    logic [31:0] aRspRdata;

    logic        bReqValid = 1'b0, bReqWe = 1'b0;
    logic [31:0] bReqAddr = '0, bReqWdata = '0;
    logic [3:0]  bReqWstrb = '0;
    logic        bReqReady, bRspValid, bRspErr, bBusy;
    logic [31:0] bRspRdata;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(aReqValid), .req_ready(aReqReady), .req_we(aReqWe),
        .req_addr(aReqAddr), .req_wdata(aReqWdata), .req_wstrb(aReqWstrb),
        .rsp_valid(aRspValid), .rsp_rdata(aRspRdata), .rsp_err(aRspErr), .busy(aBusy)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dutB (
        .clk(clk), .rst(rst),
        .req_valid(bReqValid), .req_ready(bReqReady), .req_we(bReqWe),
        .req_addr(bReqAddr), .req_wdata(bReqWdata), .req_wstrb(bReqWstrb),
        .rsp_valid(bRspValid), .rsp_rdata(bRspRdata), .rsp_err(bRspErr), .busy(bBusy)
    );

    bit sel = 1'b0;
    logic        mReqReady, mRspValid, mRspErr, mBusy;
    logic [31:0] mRspRdata;
    assign mReqReady = sel ? bReqReady : aReqReady;
    assign mRspValid = sel ? bRspValid : aRspValid;
    assign mRspErr   = sel ? bRspErr   : aRspErr;
    assign mBusy     = sel ? bBusy     : aBusy;
    assign mRspRdata = sel ? bRspRdata : aRspRdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] refMem [2][DEPTH];

    typedef struct {
        bit          sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] expRdata;
        logic        expErr;
    } vecT;
    vecT vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input bit s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] expRdata, input logic expErr);
        vecT v;
        v = '{s, we, addr, wdata, wstrb, expRdata, expErr};
        vecs.push_back(v);
    endtask

    // Reference: word-addressed array; fault on misalignment or word number >= DEPTH
    task automatic modelTxn(input bit s, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rd, output logic err);
        int unsigned wordNum;
        wordNum = addr / 4;
        err = (addr % 4 != 0) || (wordNum >= DEPTH);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) refMem[s][wordNum][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                rd = refMem[s][wordNum];
            end
        end
    endtask

    task automatic driveReq(input logic v, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        if (sel) begin
            bReqValid = v; bReqWe = we; bReqAddr = addr; bReqWdata = wdata; bReqWstrb = wstrb;
        end else begin
            aReqValid = v; aReqWe = we; aReqAddr = addr; aReqWdata = wdata; aReqWstrb = wstrb;
        end
    endtask

    // One full transaction on the selected instance, checked against the model
    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input string tag,
                         output logic [31:0] gotRdata, output logic gotErr);
        logic [31:0] expRd;
        logic        expErr;
        int          lat;
        bit          got;
        modelTxn(sel, we, addr, wdata, wstrb, expRd, expErr);
        @(negedge clk);
        driveReq(1'b1, we, addr, wdata, wstrb);
        check({tag, "_ready"}, 32'(mReqReady), 32'd1);
        @(posedge clk);
        #1;
        driveReq(1'b0, ~we, $urandom, $urandom, 4'hF);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mRspValid) begin
                got = 1'b1;
            end else begin
                check({tag, "_busy"}, {31'd0, mBusy, mReqReady}, 32'b10 >> 0);
            end
        end
        check({tag, "_latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
        gotRdata = mRspRdata;
        gotErr   = mRspErr;
        check({tag, "_rdata"}, mRspRdata, expRd);
        check({tag, "_err"}, 32'(mRspErr), 32'(expErr));
        @(negedge clk);
        check({tag, "_after"}, {28'd0, mRspValid, mRspErr, mBusy, mReqReady}, 32'b0001);
        check({tag, "_after_rdata"}, mRspRdata, 32'h0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rd;
        logic        er;
        logic [31:0] addr;
        logic [31:0] expQ[$];
        int          lastK, accCount, rspCount;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstA", {28'd0, aRspValid, aRspErr, aBusy, aReqReady}, 32'h0);
        check("rstA_rdata", aRspRdata, 32'h0);
        check("rstB", {28'd0, bRspValid, bRspErr, bBusy, bReqReady}, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", {30'd0, aReqReady, bReqReady}, 32'b11);

        // Directed vectors, 2 wait states (sel 0) then 0 wait states (sel 1)
        addVec(0, 1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0, 0);
        addVec(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        addVec(0, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
        addVec(0, 1, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 32'h0, 0);
        addVec(0, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 0);
        addVec(0, 0, 32'h0000_0012, 32'h0,         4'h0, 32'h0, 1);
        addVec(0, 1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
        addVec(0, 0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 0);
        addVec(0, 1, 32'h0000_0010, 32'h5555_5555, 4'h0, 32'h0, 0);
        addVec(0, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 0);
        addVec(0, 1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
        addVec(0, 0, 32'h0000_03FC, 32'h0,         4'h0, 32'hCAFE_F00D, 0);
        addVec(0, 0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0, 1);
        addVec(1, 1, 32'h0000_0014, 32'hA5A5_5A5A, 4'hF, 32'h0, 0);
        addVec(1, 0, 32'h0000_0014, 32'h0,         4'h0, 32'hA5A5_5A5A, 0);
        addVec(1, 0, 32'h0000_0013, 32'h0,         4'h0, 32'h0, 1);
        addVec(1, 1, 32'h0000_0814, 32'h0BAD_0BAD, 4'hF, 32'h0, 1);
        addVec(1, 1, 32'h0000_0014, 32'h00C3_0000, 4'b0100, 32'h0, 0);
        addVec(1, 0, 32'h0000_0014, 32'h0,         4'h0, 32'hA5C3_5A5A, 0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            doTxn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                  $sformatf("vec%0d", i), rd, er);
            check($sformatf("vec%0d_tbl_rdata", i), rd, vecs[i].expRdata);
            check($sformatf("vec%0d_tbl_err", i), 32'(er), 32'(vecs[i].expErr));
        end

        // Fill the whole array of instance A so random loads have defined data
        sel = 1'b0;
        for (int w = 0; w < int'(DEPTH); w++) begin
            doTxn(1'b1, 32'(w) * 4, $urandom, 4'hF, "fill", rd, er);
        end

        // Random traffic against the model
        for (int i = 0; i < 120; i++) begin
            int unsigned r;
            r = $urandom_range(9, 0);
            if (r == 0)      addr = 32'($urandom_range(255, 0)) * 4 + 32'($urandom_range(3, 1));
            else if (r == 1) addr = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            else             addr = 32'($urandom_range(255, 0)) * 4;
            doTxn(1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)),
                  $sformatf("rnd%0d", i), rd, er);
        end

        // Backpressure: req_valid held high with a new load address every cycle
        lastK = -1; accCount = 0; rspCount = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (aRspValid) begin
                rspCount++;
                if (expQ.size() == 0) check("bp_extra_rsp", 32'd1, 32'd0);
                else check("bp_rdata", aRspRdata, expQ.pop_front());
                check("bp_busy_in_resp", {30'd0, aBusy, aReqReady}, 32'b10);
            end
            addr = 32'($urandom_range(255, 0)) * 4;
            driveReq(1'b1, 1'b0, addr, $urandom, 4'hF);
            if (aReqReady) begin
                modelTxn(1'b0, 1'b0, addr, 32'h0, 4'h0, rd, er);
                expQ.push_back(rd);
                if (lastK >= 0) check("bp_gap", 32'(k - lastK), 32'd4);
                lastK = k;
                accCount++;
            end else begin
                check("bp_busy", 32'(aBusy), 32'd1);
            end
        end
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) driveReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (aRspValid) begin
                rspCount++;
                if (expQ.size() == 0) check("bp_extra_rsp", 32'd1, 32'd0);
                else check("bp_rdata", aRspRdata, expQ.pop_front());
            end
        end
        check("bp_accepted", 32'(accCount), 32'd6);
        check("bp_responses", 32'(rspCount), 32'(accCount));

        // Reset in the cycle after a store handshake drops the store
        @(negedge clk);
        driveReq(1'b1, 1'b1, 32'h0000_0020, ~refMem[0][8], 4'hF);
        check("mrst_ready", 32'(aReqReady), 32'd1);
        @(posedge clk);
        #1;
        driveReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("mrst_busy", 32'(aBusy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_in_reset", {29'd0, aRspValid, aBusy, aReqReady}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ready_after", {29'd0, aRspValid, aBusy, aReqReady}, 32'b001);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("mrst_no_rsp", 32'(aRspValid), 32'd0);
        end
        doTxn(1'b0, 32'h0000_0020, 32'h0, 4'h0, "mrst_reload", rd, er);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder side of the CPU data-memory port. It sits opposite the MEM pipeline stage and accepts one load or store request at a time over a valid/ready handshake. After a programmable number of wait states it performs the word access on an internal array, with byte strobes on stores, and returns a one-cycle response carrying read data or an error flag. A busy output lets the hazard logic stall the pipeline while a request is in flight.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two, at least 4)
WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_wstrb  input  4  byte enables for a store; bit i enables byte i
rsp_valid  output  1  response pulse, one cycle wide
rsp_rdata  output  32  load data; 0 for stores and for errors
rsp_err  output  1  access fault, qualified by rsp_valid
busy  output  1  a transaction is in flight

Behaviour:
- Reset: clk and rst (active-low, synchronous, sampled on the rising edge of clk); rst low forces state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0. The array contents are not reset.
- req_ready = (state==IDLE) && rst. It is combinational from the state only, with no dependency on req_valid.
- busy = (state!=IDLE).
- FSM states:
  - IDLE to WAIT on handshake (req_valid && req_ready) when WAIT_CYCLES>0.
  - IDLE to RESP on handshake when WAIT_CYCLES=0.
  - WAIT to RESP when the counter reaches 1; otherwise the counter decrements each cycle.
  - RESP to IDLE unconditionally.
- On handshake, capture we, addr, wdata and wstrb into holding registers and load counter=WAIT_CYCLES. Input changes after the handshake have no effect on the transaction.
- Latency: handshake at edge T; rsp_valid is high during cycle T+WAIT_CYCLES+1 only.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. req_valid seen outside IDLE is ignored and is not queued.
- Access is performed on the edge entering RESP:
  - Word index = addr[clog2(DEPTH)+1:2].
  - Fault = (addr[1:0]!=0) or (addr[31:2] >= DEPTH).
  - Fault: rsp_err=1, rsp_rdata=0, and the array is not modified.
  - Load, no fault: rsp_rdata = array[index], rsp_err=0.
  - Store, no fault: array[index] byte i <= wdata byte i for each set wstrb[i]; rsp_rdata=0, rsp_err=0. wstrb=0 is a legal no-op store.
- rsp_rdata and rsp_err are registered, hold their values while rsp_valid=1, and return to 0 on the edge leaving RESP.
- Reset mid-transaction, in WAIT or RESP: the transaction is dropped, no array write occurs, no rsp_valid pulse, and the state returns to IDLE.
- A load to the address of the immediately preceding store returns the newly stored data, since the store has completed before the next handshake.

Test Plan:
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with wstrb=1111, then load 0x10 -> each rsp_valid arrives 3 cycles after its handshake; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial store: store 0x0000AB00 with wstrb=0010 to 0x10 (previously 0xDEADBEEF), then load -> 0xDEADABEF.
- Faults: load 0x12 (misaligned), then store to 0x400 with DEPTH=256 -> both responses have rsp_err=1 and rsp_rdata=0; a load of word 0 afterwards shows it unchanged.
- Backpressure: hold req_valid=1 continuously with changing addresses -> handshakes occur only every 4 cycles; req_ready=0 and busy=1 during WAIT/RESP; exactly one response per accepted request.
- Reset mid-operation: assert rst low in the cycle after a store handshake -> no rsp_valid, target word unchanged, req_ready=1 in the first cycle after rst returns high.
- WAIT_CYCLES=0: load handshake at edge T -> rsp_valid high during cycle T+1; req_ready high again in cycle T+2.
